// File: rtl/rr_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter: requester count,
// index width and the FSM state encoding.
package rr_reg_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin selector: first asserted request scanning
// ptr, ptr+1, ... modulo 4.
module rr_pick4
  import rr_reg_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    // Scan from the farthest offset down so the closest asserted one wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Four-requester round-robin arbiter guarding one shared register; all state
// moves on the falling clock edge, reset is asynchronous active-high.
module rr_reg_arbiter
  import rr_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = N_REQ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic [1:0]         owner,
  output logic               q_valid,
  output logic               busy,
  output logic [7:0]         wr_cnt
);

  // Handshake: a requester holds req high until it sees its one-cycle gnt
  // pulse; q already carries its data in that cycle. The request must then
  // be seen low once before the same requester can be granted again.

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             do_write;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_idx),
    .found  (pick_found)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = GRANT;
      GRANT:   state_next = RELEASE;
      RELEASE: if (!req[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign do_write = (state == IDLE) && pick_found;

  // Winner and its data are captured on the IDLE->GRANT edge, so q is already
  // valid while gnt is high and later wdata changes cannot leak in.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      owner   <= '0;
      q_valid <= 1'b0;
      wr_cnt  <= '0;
      ptr     <= '0;
    end else if (do_write) begin
      q       <= wdata[pick_idx*WIDTH +: WIDTH];
      owner   <= pick_idx;
      q_valid <= 1'b1;
      wr_cnt  <= wr_cnt + 8'd1;
      ptr     <= pick_idx + 2'd1;
    end
  end

  assign gnt  = (state == GRANT) ? idx_onehot(owner) : '0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: vector table, directed corner sequences and
// random traffic checked against a transaction-level reference model.
module tb_rr_reg_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   q;
  logic [1:0]         owner;
  logic               q_valid;
  logic               busy;
  logic [7:0]         wr_cnt;

  int checks = 0;
  int passed = 0;

  rr_reg_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .owner   (owner),
    .q_valid (q_valid),
    .busy    (busy),
    .wr_cnt  (wr_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // holder: requester currently owning the register (-1 when free);
  // fresh: the holder was chosen on the last edge (its grant cycle).
  int         m_holder;
  bit         m_fresh;
  int         m_ptr;
  logic [7:0] m_q;
  int         m_owner;
  bit         m_qv;
  int         m_cnt;

  function automatic void model_reset();
    m_holder = -1;
    m_fresh  = 1'b0;
    m_ptr    = 0;
    m_q      = '0;
    m_owner  = 0;
    m_qv     = 1'b0;
    m_cnt    = 0;
  endfunction

  function automatic void model_step(input logic r, input logic [N-1:0] rq,
                                     input logic [N*WIDTH-1:0] wd);
    bit found;
    if (r) begin
      model_reset();
    end else if (m_holder < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!found && rq[i]) begin
          found    = 1'b1;
          m_holder = i;
          m_fresh  = 1'b1;
          m_q      = wd[i*WIDTH +: WIDTH];
          m_owner  = i;
          m_qv     = 1'b1;
          m_cnt    = (m_cnt + 1) % 256;
          m_ptr    = (i + 1) % N;
        end
      end
    end else if (m_fresh) begin
      m_fresh = 1'b0;
    end else if (!rq[m_holder]) begin
      m_holder = -1;
    end
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_holder >= 0 && m_fresh) g[m_holder] = 1'b1;
    return g;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, " gnt"},     32'(gnt),     32'(model_gnt()));
    check({tag, " q"},       32'(q),       32'(m_q));
    check({tag, " owner"},   32'(owner),   32'(m_owner));
    check({tag, " q_valid"}, 32'(q_valid), 32'(m_qv));
    check({tag, " busy"},    32'(busy),    32'(m_holder >= 0));
    check({tag, " wr_cnt"},  32'(wr_cnt),  32'(m_cnt));
  endtask

  // ---------------- driver ----------------
  // Inputs change just after a rising edge, the DUT samples them on the next
  // falling edge, and outputs are compared on the following rising edge.
  task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N*WIDTH-1:0] wd);
    rst   = r;
    req   = rq;
    wdata = wd;
    model_step(r, rq, wd);
    @(posedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [WIDTH-1:0] q;
    logic [1:0]       owner;
    logic             busy;
    logic [7:0]       cnt;
  } vec_t;

  vec_t tbl[13];
  localparam logic [N*WIDTH-1:0] TBL_WD = {8'hD4, 8'h3C, 8'h5A, 8'h11};

  logic [WIDTH-1:0] exp_q[$];

  initial begin
    logic [N*WIDTH-1:0] wd;
    logic [N-1:0]       cur_req;
    int                 low_cnt[N];
    int                 idx;
    int                 prev_idx;
    int                 pulses;
    logic [7:0]         cnt0;
    bit                 done;

    tbl[0]  = '{4'b0100, 4'b0100, 8'h3C, 2'd2, 1'b1, 8'd1};
    tbl[1]  = '{4'b0100, 4'b0000, 8'h3C, 2'd2, 1'b1, 8'd1};
    tbl[2]  = '{4'b0100, 4'b0000, 8'h3C, 2'd2, 1'b1, 8'd1};
    tbl[3]  = '{4'b0000, 4'b0000, 8'h3C, 2'd2, 1'b0, 8'd1};
    tbl[4]  = '{4'b0001, 4'b0001, 8'h11, 2'd0, 1'b1, 8'd2};
    tbl[5]  = '{4'b0000, 4'b0000, 8'h11, 2'd0, 1'b1, 8'd2};
    tbl[6]  = '{4'b0000, 4'b0000, 8'h11, 2'd0, 1'b0, 8'd2};
    tbl[7]  = '{4'b1010, 4'b0010, 8'h5A, 2'd1, 1'b1, 8'd3};
    tbl[8]  = '{4'b1010, 4'b0000, 8'h5A, 2'd1, 1'b1, 8'd3};
    tbl[9]  = '{4'b1000, 4'b0000, 8'h5A, 2'd1, 1'b0, 8'd3};
    tbl[10] = '{4'b1000, 4'b1000, 8'hD4, 2'd3, 1'b1, 8'd4};
    tbl[11] = '{4'b0000, 4'b0000, 8'hD4, 2'd3, 1'b1, 8'd4};
    tbl[12] = '{4'b0000, 4'b0000, 8'hD4, 2'd3, 1'b0, 8'd4};

    // reset state
    rst = 1'b1; req = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    check("reset gnt", 32'(gnt), 0);
    check("reset q", 32'(q), 0);
    check("reset q_valid", 32'(q_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset wr_cnt", 32'(wr_cnt), 0);

    // table-driven vectors
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, tbl[i].req, TBL_WD);
      check($sformatf("tbl%0d gnt", i),   32'(gnt),    32'(tbl[i].gnt));
      check($sformatf("tbl%0d q", i),     32'(q),      32'(tbl[i].q));
      check($sformatf("tbl%0d owner", i), 32'(owner),  32'(tbl[i].owner));
      check($sformatf("tbl%0d busy", i),  32'(busy),   32'(tbl[i].busy));
      check($sformatf("tbl%0d cnt", i),   32'(wr_cnt), 32'(tbl[i].cnt));
    end

    // reset mid-RELEASE takes effect without a clock edge
    wd = {8'h00, 8'h00, 8'h00, 8'hA5};
    drive(1'b0, 4'b0001, wd);
    check_model("pre_rst grant");
    drive(1'b0, 4'b0001, wd);
    check_model("pre_rst release");
    check("pre_rst q", 32'(q), 32'h A5);
    rst = 1'b1;
    #1;
    check("async_rst q", 32'(q), 0);
    check("async_rst busy", 32'(busy), 0);
    check("async_rst gnt", 32'(gnt), 0);
    check("async_rst q_valid", 32'(q_valid), 0);
    model_reset();
    drive(1'b1, 4'b0000, wd);
    check_model("in_rst");

    // first arbitration after reset starts at requester 0
    drive(1'b0, 4'b1111, TBL_WD);
    check("post_rst first gnt", 32'(gnt), 32'h1);
    check_model("post_rst");
    cur_req = 4'b1111;
    for (int i = 0; i < N; i++) low_cnt[i] = 0;
    low_cnt[0] = 2;

    // fairness: each winner lowers its request until the release has seen it
    exp_q = {8'd1, 8'd2, 8'd3, 8'd0};
    prev_idx = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (low_cnt[i] > 0) begin
          cur_req[i] = 1'b0;
          low_cnt[i]--;
        end else begin
          cur_req[i] = 1'b1;
        end
      end
      drive(1'b0, cur_req, TBL_WD);
      check_model("fair");
      if (gnt != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
        check("fair order", 32'(idx), 32'(exp_q.pop_front()));
        check("fair no_repeat", 32'(idx != prev_idx), 1);
        prev_idx = idx;
        low_cnt[idx] = 2;
        if (exp_q.size() == 0) done = 1'b1;
      end
    end
    check("fair timeout", 32'(exp_q.size()), 0);
    repeat (3) begin
      drive(1'b0, 4'b0000, TBL_WD);
      check_model("fair_drain");
    end

    // held request gives exactly one write
    cnt0 = wr_cnt;
    pulses = 0;
    repeat (10) begin
      drive(1'b0, 4'b0010, TBL_WD);
      check_model("held");
      if (gnt[1]) pulses++;
    end
    repeat (2) begin
      drive(1'b0, 4'b0000, TBL_WD);
      check_model("held_drain");
    end
    check("held pulses", 32'(pulses), 1);
    check("held wr_cnt", 32'(wr_cnt), 32'(8'(cnt0 + 8'd1)));

    // request arriving during RELEASE stays pending
    wd = {8'hE7, 8'h00, 8'h00, 8'h0F};
    drive(1'b0, 4'b0001, wd);
    check("pend gnt0", 32'(gnt), 32'h1);
    drive(1'b0, 4'b0001, wd);
    check_model("pend release");
    drive(1'b0, 4'b1001, wd);
    check_model("pend raise3");
    drive(1'b0, 4'b1000, wd);
    check("pend idle busy", 32'(busy), 0);
    drive(1'b0, 4'b1000, wd);
    check("pend gnt3", 32'(gnt), 32'h8);
    check("pend q", 32'(q), 32'h E7);
    repeat (2) begin
      drive(1'b0, 4'b0000, wd);
      check_model("pend_drain");
    end

    // 256 writes from reset wrap the counter to zero
    drive(1'b1, 4'b0000, wd);
    check_model("wrap_rst");
    for (int i = 0; i < 256; i++) begin
      wd = {$urandom, $urandom} ;
      drive(1'b0, 4'b0001, wd);
      check_model("wrap grant");
      drive(1'b0, 4'b0000, wd);
      drive(1'b0, 4'b0000, wd);
      if (i == 254) check("wrap cnt255", 32'(wr_cnt), 32'hFF);
    end
    check("wrap cnt0", 32'(wr_cnt), 0);
    check("wrap q_valid", 32'(q_valid), 1);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), {$urandom, $urandom});
      check_model("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
